// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes and default datapath widths shared by the execute stage
package alu_pkg;
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_BAD = 4'd15;
    localparam int ALU_DW = 32;
    localparam int ALU_RW = 5;
    localparam int EX_FLAG_W = 4;
    function automatic int ex_bundle_w(input int dw, input int rw);
        return dw + rw + EX_FLAG_W;
    endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU (a, b, code, unsigned_num -> result, zero, ovf, illegal); ovf reported only with ALU_OVF_TRAP_EN
module alu_core
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    code,
    input  logic          unsigned_num,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          ovf,
    output logic          illegal
);
    logic [DW-1:0] sum, diff;
    logic          lt;
    assign sum  = a + b;
    assign diff = a - b;
    assign lt   = unsigned_num ? (a < b) : ($signed(a) < $signed(b));
    always_comb begin
        illegal = 1'b0;
        result  = '0;
        case (code)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_SLT: result = {{(DW-1){1'b0}}, lt};
            ALU_NOR: result = ~(a | b);
            default: illegal = 1'b1;
        endcase
    end
    assign zero = result == '0;
`ifdef ALU_OVF_TRAP_EN
    assign ovf = !unsigned_num &&
                 ((code == ALU_ADD && a[DW-1] == b[DW-1] && sum[DW-1] != a[DW-1]) ||
                  (code == ALU_SUB && a[DW-1] != b[DW-1] && diff[DW-1] != a[DW-1]));
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with 2-entry skid output register, valid/ready handshake, jr redirect and flush
// Ports: clk/rst_n (sync active-low), flush; in_valid/in_ready with alu_control, unsigned_num,
// jmp_reg, src_a, src_b, wr_reg, reg_write; out_valid/out_ready with out_result, out_wr_reg,
// out_reg_write, out_zero, out_ovf, out_illegal; redirect_valid/redirect_pc.
// Optional ALU_OVF_TRAP_EN: overflow suppresses the register write and is reported on out_ovf.
module ex_stage
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int RW = ALU_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    alu_control,
    input  logic          unsigned_num,
    input  logic          jmp_reg,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    input  logic [RW-1:0] wr_reg,
    input  logic          reg_write,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_wr_reg,
    output logic          out_reg_write,
    output logic          out_zero,
    output logic          out_ovf,
    output logic          out_illegal,
    output logic          redirect_valid,
    output logic [DW-1:0] redirect_pc
);
    typedef struct packed {
        logic [DW-1:0] result;
        logic [RW-1:0] wr_reg;
        logic          reg_write;
        logic          zero;
        logic          ovf;
        logic          illegal;
    } ex_t;
    ex_t           new_op, main_q, main_d, skid_q, skid_d;
    logic          main_v_q, main_v_d, skid_v_q, skid_v_d, redir_v_q, redir_v_d;
    logic [DW-1:0] redir_pc_q, redir_pc_d, res;
    logic          zero, ovf, illegal, accept;
    alu_core #(.DW(DW)) u_alu (
        .a(src_a), .b(src_b), .code(alu_control), .unsigned_num(unsigned_num),
        .result(res), .zero(zero), .ovf(ovf), .illegal(illegal)
    );
    assign in_ready = !skid_v_q;
    assign accept   = in_valid && in_ready && !flush;
    assign new_op   = '{result: res, wr_reg: wr_reg, zero: zero, ovf: ovf, illegal: illegal,
                        reg_write: reg_write && !jmp_reg && !illegal && !ovf};
    always_comb begin
        main_v_d   = main_v_q;
        main_d     = main_q;
        skid_v_d   = skid_v_q;
        skid_d     = skid_q;
        // skid advances into main on transfer; an accept lands in whichever entry is then free
        if (main_v_q && out_ready) begin
            main_v_d = skid_v_q;
            main_d   = skid_q;
            skid_v_d = 1'b0;
        end
        if (accept && !main_v_d) begin
            main_v_d = 1'b1;
            main_d   = new_op;
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d   = new_op;
        end
        main_v_d   = main_v_d && !flush;
        skid_v_d   = skid_v_d && !flush;
        redir_v_d  = accept && jmp_reg;
        redir_pc_d = redir_v_d ? src_a : redir_pc_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
        end
    end
    assign out_valid      = main_v_q;
    assign out_result     = main_q.result;
    assign out_wr_reg     = main_q.wr_reg;
    assign out_reg_write  = main_q.reg_write;
    assign out_zero       = main_q.zero;
    assign out_ovf        = main_q.ovf;
    assign out_illegal    = main_q.illegal;
    assign redirect_valid = redir_v_q;
    assign redirect_pc    = redir_pc_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: random and directed stimulus against a queue-based reference model of ex_stage
module tb_ex_stage;
    import alu_pkg::*;
    localparam int DW = 32;
    localparam int RW = 5;
    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [3:0]    alu_control = 4'd0;
    logic          unsigned_num = 1'b0, jmp_reg = 1'b0, reg_write = 1'b0;
    logic [DW-1:0] src_a = '0, src_b = '0, out_result, redirect_pc;
    logic [RW-1:0] wr_reg = '0, out_wr_reg;
    logic          out_valid, out_ready = 1'b0, out_reg_write, out_zero, out_ovf, out_illegal, redirect_valid;
    ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .unsigned_num(unsigned_num), .jmp_reg(jmp_reg),
        .src_a(src_a), .src_b(src_b), .wr_reg(wr_reg), .reg_write(reg_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_wr_reg(out_wr_reg), .out_reg_write(out_reg_write), .out_zero(out_zero),
        .out_ovf(out_ovf), .out_illegal(out_illegal), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wr;
        logic        we, zero, ovf, ill;
    } exp_t;
    exp_t        q[$];
    logic        exp_rv = 1'b0;
    logic [31:0] exp_rpc = '0;
    int          checks = 0, errors = 0;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
        end
    endtask
    // reference ALU from arithmetic on 64-bit signed values
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic u, input logic jr, input logic rw, input logic [4:0] wr);
        exp_t   e;
        longint sa, sb, s;
        logic   v, trap;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        v  = 1'b0;
        e  = '0;
        e.wr = wr;
        case (c)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  begin s = sa + sb; e.res = s[31:0]; end
            4'd6:  begin s = sa - sb; e.res = s[31:0]; end
            4'd7:  e.res = u ? {31'b0, a < b} : {31'b0, sa < sb};
            4'd12: e.res = ~(a | b);
            default: e.ill = 1'b1;
        endcase
        if ((c == 4'd2 || c == 4'd6) && !u) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef ALU_OVF_TRAP_EN
        trap = v;
`else
        trap = 1'b0;
`endif
        e.ovf  = trap;
        e.zero = e.res == 0;
        e.we   = rw && !jr && !e.ill && !trap;
        return e;
    endfunction
    always @(negedge clk) begin
        logic acc;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_wr_reg", out_wr_reg, q[0].wr);
            chk("out_reg_write", out_reg_write, q[0].we);
            chk("out_zero", out_zero, q[0].zero);
            chk("out_ovf", out_ovf, q[0].ovf);
            chk("out_illegal", out_illegal, q[0].ill);
        end
        chk("redirect_valid", redirect_valid, exp_rv);
        if (exp_rv) chk("redirect_pc", redirect_pc, exp_rpc);
        acc = in_valid && q.size() < 2 && !flush;
        if (!rst_n) begin
            q.delete();
            exp_rv = 1'b0;
        end else begin
            exp_rv = acc && jmp_reg;
            if (exp_rv) exp_rpc = src_a;
            if (flush) q.delete();
            else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (acc) q.push_back(model(alu_control, src_a, src_b, unsigned_num, jmp_reg, reg_write, wr_reg));
            end
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic u, input logic jr, input logic [4:0] wr);
        alu_control = c; src_a = a; src_b = b; unsigned_num = u; jmp_reg = jr;
        wr_reg = wr; reg_write = 1'b1; in_valid = 1'b1;
    endtask
    task automatic one(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic u);
        op(c, a, b, u, 1'b0, 5'd9);
        cyc();
        in_valid = 1'b0;
    endtask
    logic [4:0]  got[$];
    logic        acc_now;
    logic [3:0]  codes[8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15, 4'd3};
    logic [31:0] edges[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h5};
    function automatic logic [31:0] rval();
        return ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
    endfunction
    initial begin
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outs", {out_result, out_wr_reg, out_reg_write, out_zero, out_ovf, out_illegal}, 0);
        chk("rst_redirect", {redirect_valid, redirect_pc}, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        one(ALU_ADD, 32'd7, 32'd5, 1'b0);
        chk("add_valid", out_valid, 1);
        chk("add_result", out_result, 12);
        chk("add_zero", out_zero, 0);
        chk("add_we", out_reg_write, 1);
        one(ALU_ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
        chk("ovf_result", out_result, 32'h80000000);
`ifdef ALU_OVF_TRAP_EN
        chk("ovf_flag", out_ovf, 1);
        chk("ovf_we", out_reg_write, 0);
`else
        chk("ovf_flag", out_ovf, 0);
        chk("ovf_we", out_reg_write, 1);
`endif
        one(ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b0);
        chk("slt_signed", out_result, 1);
        one(ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b1);
        chk("slt_unsigned", out_result, 0);
        one(ALU_SUB, 32'd5, 32'd5, 1'b0);
        chk("sub_result", out_result, 0);
        chk("sub_zero", out_zero, 1);
        one(ALU_NOR, 32'h0F0F0000, 32'h000000FF, 1'b0);
        chk("nor_result", out_result, 32'hF0F0FF00);
        cyc();
        out_ready = 1'b0;
        op(ALU_ADD, 32'd1, 32'd0, 1'b0, 1'b0, 5'd1);
        cyc();
        chk("stall_ready1", in_ready, 1);
        op(ALU_ADD, 32'd2, 32'd0, 1'b0, 1'b0, 5'd2);
        cyc();
        chk("stall_ready2", in_ready, 0);
        op(ALU_ADD, 32'd3, 32'd0, 1'b0, 1'b0, 5'd3);
        cyc();
        cyc();
        chk("stall_hold_wr", out_wr_reg, 1);
        chk("stall_hold_res", out_result, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) got.push_back(out_wr_reg);
            acc_now = in_valid && in_ready;
            cyc();
            if (acc_now) in_valid = 1'b0;
        end
        chk("order_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("order_item", got[i], i + 1);
        op(ALU_ADD, 32'hBFC00100, 32'd4, 1'b0, 1'b1, 5'd31);
        cyc();
        in_valid = 1'b0;
        chk("jr_redirect", redirect_valid, 1);
        chk("jr_pc", redirect_pc, 32'hBFC00100);
        chk("jr_we", out_reg_write, 0);
        cyc();
        chk("jr_pulse_end", redirect_valid, 0);
        op(ALU_ADD, 32'hBFC00100, 32'd4, 1'b0, 1'b1, 5'd31);
        flush = 1'b1;
        cyc();
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_redirect", redirect_valid, 0);
        chk("flush_valid", out_valid, 0);
        one(ALU_BAD, 32'd3, 32'd4, 1'b0);
        chk("bad_illegal", out_illegal, 1);
        chk("bad_result", out_result, 0);
        chk("bad_we", out_reg_write, 0);
        out_ready = 1'b0;
        op(ALU_OR, 32'd1, 32'd2, 1'b0, 1'b0, 5'd4);
        cyc();
        op(ALU_OR, 32'd3, 32'd4, 1'b0, 1'b0, 5'd5);
        cyc();
        chk("full_ready", in_ready, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_stall_valid", out_valid, 0);
        chk("rst_stall_ready", in_ready, 1);
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !in_ready)) begin
                alu_control  = codes[$urandom_range(0, 7)];
                if (alu_control == 4'd3) alu_control = 4'($urandom);
                src_a        = rval();
                src_b        = rval();
                unsigned_num = $urandom_range(0, 3) == 0;
                jmp_reg      = $urandom_range(0, 7) == 0;
                reg_write    = $urandom_range(0, 3) != 0;
                wr_reg       = 5'($urandom);
                in_valid     = $urandom_range(0, 3) != 0;
            end
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 31) == 0;
            rst_n     = $urandom_range(0, 199) != 0;
            cyc();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
